// File: rtl/cordic_angle_sweep.sv
// cordic_angle_sweep: steps a wrapped phase accumulator through a sweep of
// angles and sequences the CORDIC rotation core once per angle.
// Each angle is folded into [-90, 90] degrees by negating the x seed. The
// sequencer pulses the core reset, waits ITERS+1 cycles, then strobes sample.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start, stop       begin a sweep (IDLE only) / end after the current angle
//   step, count       Q8.8 degrees per angle / number of angles (0 = continuous)
//   x_o, y_o, theta_o core seed and folded angle (Q8.8)
//   cordic_rst        one-cycle core reset per angle
//   angle_o           unfolded wrapped angle (Q8.8)
//   sample, busy      core output valid strobe / sweep in progress
module cordic_angle_sweep #(
  parameter int unsigned ITERS  = 16,
  parameter logic [16:0] X_GAIN = 17'd19896
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [16:0] step,
  input  logic [7:0]  count,
  output logic [16:0] x_o,
  output logic [16:0] y_o,
  output logic [16:0] theta_o,
  output logic        cordic_rst,
  output logic [16:0] angle_o,
  output logic        sample,
  output logic        busy
);

  localparam int unsigned AW     = 17;
  localparam int unsigned ACC_W  = 19;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned ITER_W = $clog2(ITERS + 1);

  localparam logic signed [ACC_W-1:0] DEG90   = 19'sd23040;
  localparam logic signed [ACC_W-1:0] NDEG90  = -19'sd23040;
  localparam logic signed [ACC_W-1:0] DEG180  = 19'sd46080;
  localparam logic signed [ACC_W-1:0] NDEG180 = -19'sd46080;
  localparam logic signed [ACC_W-1:0] DEG360  = 19'sd92160;

  localparam logic [AW-1:0] X_NEG = ~X_GAIN + 17'd1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] step_q, step_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [CNT_W-1:0]        rem_q, rem_d;
  logic [ITER_W-1:0]       iter_q, iter_d;
  logic                    stop_q, stop_d;
  logic [AW-1:0]           x_q, x_d;
  logic [AW-1:0]           theta_q, theta_d;
  logic [AW-1:0]           angle_q, angle_d;
  logic                    crst_q, crst_d;
  logic                    sample_q, sample_d;
  logic                    busy_q, busy_d;

  logic signed [ACC_W-1:0] step_ext;
  logic signed [ACC_W-1:0] step_clamp;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] acc_wrap;
  logic [CNT_W-1:0]        rem_dec;
  logic                    stop_seen;

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    step_d   = step_q;
    count_d  = count_q;
    rem_d    = rem_q;
    iter_d   = iter_q;
    stop_d   = stop_q;
    x_d      = x_q;
    theta_d  = theta_q;
    angle_d  = angle_q;
    crst_d   = 1'b0;
    sample_d = 1'b0;

    // Clamp to +/-180 so a single wrap correction per step is enough
    step_ext = {{2{step[16]}}, step};
    if (step_ext > DEG180)       step_clamp = DEG180;
    else if (step_ext < NDEG180) step_clamp = NDEG180;
    else                         step_clamp = step_ext;

    acc_sum = acc_q + step_q;
    if (acc_sum >= DEG180)      acc_wrap = acc_sum - DEG360;
    else if (acc_sum < NDEG180) acc_wrap = acc_sum + DEG360;
    else                        acc_wrap = acc_sum;

    rem_dec   = rem_q - CNT_W'(1);
    stop_seen = stop_q | stop;

    unique case (state_q)
      IDLE: begin
        stop_d = 1'b0;
        if (start) begin
          acc_d   = '0;
          step_d  = step_clamp;
          count_d = count;
          rem_d   = count;
          state_d = LOAD;
        end
      end
      LOAD: begin
        stop_d = stop_seen;
        // Fold into the CORDIC convergence range; exactly +/-90 stays put
        if (acc_q > DEG90) begin
          theta_d = AW'(acc_q - DEG180);
          x_d     = X_NEG;
        end else if (acc_q < NDEG90) begin
          theta_d = AW'(acc_q + DEG180);
          x_d     = X_NEG;
        end else begin
          theta_d = AW'(acc_q);
          x_d     = X_GAIN;
        end
        angle_d = AW'(acc_q);
        crst_d  = 1'b1;
        iter_d  = '0;
        state_d = RUN;
      end
      RUN: begin
        stop_d = stop_seen;
        if (iter_q == ITER_W'(ITERS)) begin
          sample_d = 1'b1;
          state_d  = DONE;
        end else begin
          iter_d = iter_q + ITER_W'(1);
        end
      end
      DONE: begin
        acc_d = acc_wrap;
        if (count_q != '0) rem_d = rem_dec;
        if (stop_seen || ((count_q != '0) && (rem_dec == '0))) begin
          stop_d  = 1'b0;
          state_d = IDLE;
        end else begin
          stop_d  = stop_seen;
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      step_q   <= '0;
      count_q  <= '0;
      rem_q    <= '0;
      iter_q   <= '0;
      stop_q   <= 1'b0;
      x_q      <= X_GAIN;
      theta_q  <= '0;
      angle_q  <= '0;
      crst_q   <= 1'b0;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      step_q   <= step_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      iter_q   <= iter_d;
      stop_q   <= stop_d;
      x_q      <= x_d;
      theta_q  <= theta_d;
      angle_q  <= angle_d;
      crst_q   <= crst_d;
      sample_q <= sample_d;
      busy_q   <= busy_d;
    end
  end

  assign x_o        = x_q;
  assign y_o        = '0;
  assign theta_o    = theta_q;
  assign angle_o    = angle_q;
  assign cordic_rst = crst_q;
  assign sample     = sample_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_cordic_angle_sweep.sv
// tb_cordic_angle_sweep: directed, table-driven checks of the angle sweep
// sequencer, plus hand-written reset-mid-run and idle-stop sequences.
module tb_cordic_angle_sweep;

  localparam int unsigned ITERS = 16;
  localparam int PERIOD = ITERS + 3;
  localparam logic [16:0] XP = 17'h04DB8;
  localparam logic [16:0] XN = 17'h1B248;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic [16:0] step;
  logic [7:0]  count;
  logic [16:0] x_o;
  logic [16:0] y_o;
  logic [16:0] theta_o;
  logic        cordic_rst;
  logic [16:0] angle_o;
  logic        sample;
  logic        busy;

  cordic_angle_sweep #(.ITERS(ITERS), .X_GAIN(17'd19896)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .step       (step),
    .count      (count),
    .x_o        (x_o),
    .y_o        (y_o),
    .theta_o    (theta_o),
    .cordic_rst (cordic_rst),
    .angle_o    (angle_o),
    .sample     (sample),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string         tag;
    logic [16:0]   step;
    logic [7:0]    count;
    int            n;
    int            stop_at;
    int            restart_at;
    logic [5:0][16:0] ang;
    logic [5:0][16:0] th;
    logic [5:0][16:0] x;
  } vec_t;

  function automatic logic [5:0][16:0] p6(input logic [16:0] a0, input logic [16:0] a1,
                                          input logic [16:0] a2, input logic [16:0] a3,
                                          input logic [16:0] a4, input logic [16:0] a5);
    return {a5, a4, a3, a2, a1, a0};
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_x"}, 32'(x_o), 32'(XP));
    chk({tag, "_y"}, 32'(y_o), 32'd0);
    chk({tag, "_theta"}, 32'(theta_o), 32'd0);
    chk({tag, "_angle"}, 32'(angle_o), 32'd0);
    chk({tag, "_crst"}, 32'(cordic_rst), 32'd0);
    chk({tag, "_sample"}, 32'(sample), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // cyc counts negedges after the edge that sampled start (LOAD is cyc 1)
  task automatic run_sweep(input vec_t v);
    int cyc;
    int k;
    int rc;
    int last;
    int limit;
    @(negedge clk);
    start = 1'b1;
    step  = v.step;
    count = v.count;
    @(negedge clk);
    start = 1'b0;
    step  = 17'h0;
    count = 8'd0;
    cyc   = 1;
    k     = 0;
    rc    = 0;
    last  = -10;
    limit = PERIOD * v.n + 8;
    chk({v.tag, "_busy_start"}, 32'(busy), 32'd1);
    while (cyc <= limit) begin
      if (cordic_rst) rc++;
      if (sample) begin
        if (k < v.n) begin
          chk($sformatf("%s_cyc%0d", v.tag, k), 32'(cyc), 32'(PERIOD * (k + 1)));
          chk($sformatf("%s_ang%0d", v.tag, k), 32'(angle_o), 32'(v.ang[k]));
          chk($sformatf("%s_th%0d", v.tag, k), 32'(theta_o), 32'(v.th[k]));
          chk($sformatf("%s_x%0d", v.tag, k), 32'(x_o), 32'(v.x[k]));
          chk($sformatf("%s_y%0d", v.tag, k), 32'(y_o), 32'd0);
        end
        k++;
        last = cyc;
      end
      if (k == v.n && cyc == last + 1)
        chk({v.tag, "_busy_end"}, 32'(busy), 32'd0);
      stop  = (cyc == v.stop_at);
      start = (cyc == v.restart_at);
      step  = (cyc == v.restart_at) ? 17'h06400 : 17'h0;
      @(negedge clk);
      cyc++;
    end
    stop  = 1'b0;
    start = 1'b0;
    chk({v.tag, "_nsamples"}, 32'(k), 32'(v.n));
    chk({v.tag, "_ncrst"}, 32'(rc), 32'(v.n));
  endtask

  vec_t vecs[6];

  initial begin
    int sc;
    int bz;
    vecs[0] = '{"fold", 17'h02D00, 8'd4, 4, 0, 0,
                p6(17'h00000, 17'h02D00, 17'h05A00, 17'h08700, 17'h0, 17'h0),
                p6(17'h00000, 17'h02D00, 17'h05A00, 17'h1D300, 17'h0, 17'h0),
                p6(XP, XP, XP, XN, 17'h0, 17'h0)};
    vecs[1] = '{"wrap", 17'h06400, 8'd3, 3, 0, 0,
                p6(17'h00000, 17'h06400, 17'h16000, 17'h0, 17'h0, 17'h0),
                p6(17'h00000, 17'h1B000, 17'h01400, 17'h0, 17'h0, 17'h0),
                p6(XP, XN, XN, 17'h0, 17'h0, 17'h0)};
    vecs[2] = '{"clamp", 17'h0FFFF, 8'd2, 2, 0, 0,
                p6(17'h00000, 17'h14C00, 17'h0, 17'h0, 17'h0, 17'h0),
                p6(17'h00000, 17'h00000, 17'h0, 17'h0, 17'h0, 17'h0),
                p6(XP, XN, 17'h0, 17'h0, 17'h0, 17'h0)};
    vecs[3] = '{"count1", 17'h02D00, 8'd1, 1, 0, 0,
                p6(17'h00000, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0),
                p6(17'h00000, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0),
                p6(XP, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0)};
    vecs[4] = '{"negstep", 17'h1D300, 8'd4, 4, 0, 0,
                p6(17'h00000, 17'h1D300, 17'h1A600, 17'h17900, 17'h0, 17'h0),
                p6(17'h00000, 17'h1D300, 17'h1A600, 17'h02D00, 17'h0, 17'h0),
                p6(XP, XP, XP, XN, 17'h0, 17'h0)};
    vecs[5] = '{"contstop", 17'h05A00, 8'd0, 6, 105, 0,
                p6(17'h00000, 17'h05A00, 17'h14C00, 17'h1A600, 17'h00000, 17'h05A00),
                p6(17'h00000, 17'h05A00, 17'h00000, 17'h1A600, 17'h00000, 17'h05A00),
                p6(XP, XP, XN, XP, XP, XP)};

    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    step  = 17'h0;
    count = 8'd0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;

    // stop in IDLE is ignored
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("idle_stop_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 6; i++) run_sweep(vecs[i]);

    // start during RUN with another step must not disturb the sweep
    begin
      vec_t v;
      v = '{"busystart", 17'h02D00, 8'd3, 3, 0, 10,
            p6(17'h00000, 17'h02D00, 17'h05A00, 17'h0, 17'h0, 17'h0),
            p6(17'h00000, 17'h02D00, 17'h05A00, 17'h0, 17'h0, 17'h0),
            p6(XP, XP, XP, 17'h0, 17'h0, 17'h0)};
      run_sweep(v);
    end

    // reset five cycles into RUN of the second angle
    @(negedge clk);
    start = 1'b1;
    step  = 17'h05A00;
    count = 8'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (24) @(negedge clk);
    chk("midrst_pre_theta", 32'(theta_o), 32'h05A00);
    chk("midrst_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("midrst");
    sc = 0;
    bz = 0;
    repeat (40) begin
      @(negedge clk);
      sc += int'(sample);
      bz += int'(busy);
    end
    chk("midrst_nsample", 32'(sc), 32'd0);
    chk("midrst_nbusy", 32'(bz), 32'd0);
    vecs[3].tag = "restart";
    run_sweep(vecs[3]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
